// File: rtl/hazard_if.sv
// hazard_if: pipeline hazard-status and control bundle between the datapath and hazard_ctrl.
interface hazard_if #(parameter int PERF_W = 16);
    logic [4:0] i_rs1D, i_rs2D, i_rs1E, i_rs2E, i_rdE, i_rdM, i_rdW;
    logic i_rd_wrenE, i_rd_wrenM, i_rd_wrenW;
    logic [1:0] i_wb_selE;
    logic i_pc_selE, i_lsu_reqM, i_lsu_ackM;
    logic o_stallF, o_stallD, o_stallE, o_stallM;
    logic o_flushD, o_flushE, o_flushW;
    logic [1:0] o_fwd_aE, o_fwd_bE;
    logic o_mem_err;
    logic [PERF_W-1:0] o_stall_cnt;
    modport master (
        output i_rs1D, i_rs2D, i_rs1E, i_rs2E, i_rdE, i_rdM, i_rdW,
        output i_rd_wrenE, i_rd_wrenM, i_rd_wrenW, i_wb_selE, i_pc_selE, i_lsu_reqM, i_lsu_ackM,
        input o_stallF, o_stallD, o_stallE, o_stallM, o_flushD, o_flushE, o_flushW,
        input o_fwd_aE, o_fwd_bE, o_mem_err, o_stall_cnt
    );
    modport slave (
        input i_rs1D, i_rs2D, i_rs1E, i_rs2E, i_rdE, i_rdM, i_rdW,
        input i_rd_wrenE, i_rd_wrenM, i_rd_wrenW, i_wb_selE, i_pc_selE, i_lsu_reqM, i_lsu_ackM,
        output o_stallF, o_stallD, o_stallE, o_stallM, o_flushD, o_flushE, o_flushW,
        output o_fwd_aE, o_fwd_bE, o_mem_err, o_stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding control for the 5-stage pipeline, with LSU wait FSM and stall counter.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int PERF_W      = 16
) (
    input logic     i_clk,
    input logic     i_rst_n,
    hazard_if.slave hz
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [1:0] RUN = 2'd0, MEM_WAIT = 2'd1, ERR = 2'd2;
    logic [1:0] state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    logic mem_busy, load_use, hold, br, lu;
    always_comb begin
        mem_busy = hz.i_lsu_reqM && !hz.i_lsu_ackM;
        load_use = hz.i_rd_wrenE && hz.i_wb_selE == 2'b01 && hz.i_rdE != 5'd0 &&
                   (hz.i_rdE == hz.i_rs1D || hz.i_rdE == hz.i_rs2D);
        hold = state_q == ERR || mem_busy;
        br   = !hold && hz.i_pc_selE;
        // a load-use hit on a wrong-path D instruction is dropped in favour of the redirect
        lu   = !hold && !hz.i_pc_selE && load_use;
        hz.o_stallF = i_rst_n && (hold || lu);
        hz.o_stallD = i_rst_n && (hold || lu);
        hz.o_stallE = i_rst_n && hold;
        hz.o_stallM = i_rst_n && hold;
        hz.o_flushD = i_rst_n && br;
        hz.o_flushE = i_rst_n && (br || lu);
        hz.o_flushW = i_rst_n && hold;
        hz.o_fwd_aE = !i_rst_n ? 2'b00 :
                      (hz.i_rd_wrenM && hz.i_rdM != 5'd0 && hz.i_rdM == hz.i_rs1E) ? 2'b10 :
                      (hz.i_rd_wrenW && hz.i_rdW != 5'd0 && hz.i_rdW == hz.i_rs1E) ? 2'b01 : 2'b00;
        hz.o_fwd_bE = !i_rst_n ? 2'b00 :
                      (hz.i_rd_wrenM && hz.i_rdM != 5'd0 && hz.i_rdM == hz.i_rs2E) ? 2'b10 :
                      (hz.i_rd_wrenW && hz.i_rdW != 5'd0 && hz.i_rdW == hz.i_rs2E) ? 2'b01 : 2'b00;
        hz.o_mem_err    = state_q == ERR;
        hz.o_stall_cnt  = stall_cnt_q;
        stall_cnt_d = stall_cnt_q + PERF_W'(hz.o_stallF && !(&stall_cnt_q));
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        if (state_q == RUN && mem_busy) begin
            state_d    = MEM_WAIT;
            wait_cnt_d = CW'(1);
        end else if (state_q == MEM_WAIT) begin
            // a dropped request counts as completion
            if (!mem_busy) begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end else if (wait_cnt_q == CW'(MEM_TIMEOUT)) begin
                state_d = ERR;
            end else begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule
